// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter -- writeback stage feeding the register-file write port.
//
// Execute results and memory load responses share the single regfile write
// port. Execute always wins; loads that arrive while execute owns the port are
// formatted (byte/half extraction, sign/zero extension) on accept and parked
// in a small in-order queue. The write port outputs are registered so they are
// stable ahead of the regfile's negedge write.
//
// Ports
//   clk          clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   alu_valid    execute result requests a write this cycle
//   alu_rd       execute destination register
//   alu_data     execute result
//   ld_valid     load response valid
//   ld_ready     load queue can accept (count < LQ_DEPTH, no same-cycle pop)
//   ld_rd        load destination register
//   ld_funct3    000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (others as LW)
//   ld_addr_lo   load address bits [1:0]
//   ld_data      raw aligned memory word
//   we/wa/wd     registered regfile write enable / address / data
//   pend_mask    one-hot OR of rd over live queued loads (decode hazard stall)
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] ld_data,
    output logic            we,
    output logic [4:0]      wa,
    output logic [XLEN-1:0] wd,
    output logic [31:0]     pend_mask
);

    localparam int AW = $clog2(LQ_DEPTH);
    localparam int CW = AW + 1;

    // Queue kept compacted: entries [0 .. count_q-1] are live, entry 0 is the head.
    logic [4:0]      rd_q   [LQ_DEPTH];
    logic [4:0]      rd_d   [LQ_DEPTH];
    logic [XLEN-1:0] data_q [LQ_DEPTH];
    logic [XLEN-1:0] data_d [LQ_DEPTH];
    logic [CW-1:0]   count_q, count_d;

    logic            we_q;
    logic [4:0]      wa_q;
    logic [XLEN-1:0] wd_q;

    logic            alu_req, ld_acc, pop, bypass, enq;
    logic [XLEN-1:0] ld_fmt;
    logic [31:0]     pend_d;

    function automatic logic [XLEN-1:0] fmt_load(input logic [2:0]      f3,
                                                 input logic [1:0]      lo,
                                                 input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = w[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return w;
        endcase
    endfunction

    // Writes to x0 are meaningless, so an ALU request to x0 is no request.
    assign alu_req  = alu_valid && (alu_rd != 5'd0);
    assign ld_ready = (count_q < CW'(LQ_DEPTH));
    assign ld_acc   = ld_valid && ld_ready;
    assign ld_fmt   = fmt_load(ld_funct3, ld_addr_lo, ld_data);
    assign pop      = !alu_req && (count_q != '0);
    assign bypass   = !alu_req && (count_q == '0) && ld_acc && (ld_rd != 5'd0);
    assign enq      = ld_acc && (ld_rd != 5'd0) && !bypass;

    // Next queue contents: drop the popped head and any entry killed by an
    // ALU write to the same rd (WAW), close the gaps, then append the new load.
    // A same-cycle load with the ALU's rd is younger, so it is appended normally.
    always_comb begin
        logic [CW-1:0] n;
        logic          kill;
        rd_d   = rd_q;
        data_d = data_q;
        pend_d = '0;
        n      = '0;
        kill   = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                kill = alu_req && (rd_q[i] == alu_rd);
                if (!kill) begin
                    pend_d[rd_q[i]] = 1'b1;
                end
                if (!kill && !(pop && (i == 0))) begin
                    rd_d[n[AW-1:0]]   = rd_q[i];
                    data_d[n[AW-1:0]] = data_q[i];
                    n = n + CW'(1);
                end
            end
        end
        if (enq) begin
            rd_d[n[AW-1:0]]   = ld_rd;
            data_d[n[AW-1:0]] = ld_fmt;
            n = n + CW'(1);
        end
        count_d = n;
    end

    assign pend_mask = pend_d;

    // Queue payload carries no reset; count_q alone defines which slots are live.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    // Write-port arbitration: ALU, then queue head, then bypassed load, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            we_q    <= 1'b0;
            wa_q    <= 5'd0;
            wd_q    <= '0;
        end else begin
            count_q <= count_d;
            if (alu_req) begin
                we_q <= 1'b1;
                wa_q <= alu_rd;
                wd_q <= alu_data;
            end else if (count_q != '0) begin
                we_q <= 1'b1;
                wa_q <= rd_q[0];
                wd_q <= data_q[0];
            end else if (bypass) begin
                we_q <= 1'b1;
                wa_q <= ld_rd;
                wd_q <= ld_fmt;
            end else begin
                we_q <= 1'b0;
            end
        end
    end

    assign we = we_q;
    assign wa = wa_q;
    assign wd = wd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for wb_arbiter: directed stimulus, a queue-based reference model
// updated on each posedge, a negedge compare process, and literal checks for
// the hand-worked scenarios.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] ld_data;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pend_mask;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    wb_arbiter #(.XLEN(32), .LQ_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_funct3 (ld_funct3),
        .ld_addr_lo(ld_addr_lo),
        .ld_data   (ld_data),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference load formatting: shift the wanted lane down, then extend.
    function automatic logic [31:0] mfmt(input logic [2:0] f3, input logic [1:0] lo,
                                         input logic [31:0] d);
        logic [31:0] bl, hl;
        bl = d >> (8 * lo);
        hl = d >> (lo[1] ? 16 : 0);
        case (f3)
            3'b000:  return 32'($signed(bl[7:0]));
            3'b001:  return 32'($signed(hl[15:0]));
            3'b100:  return bl & 32'h0000_00FF;
            3'b101:  return hl & 32'h0000_FFFF;
            default: return d;
        endcase
    endfunction

    // Reference model state
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = 5'd0;
    logic [31:0] m_wd = 32'd0;

    initial begin
        bit   a, acc, used;
        ent_t le, hd;
        ent_t keep[$];
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_we = 1'b0;
                m_wa = 5'd0;
                m_wd = 32'd0;
            end else begin
                a    = alu_valid && (alu_rd != 5'd0);
                acc  = ld_valid && (mq.size() < DEPTH);
                used = 1'b0;
                le.rd = ld_rd;
                le.d  = mfmt(ld_funct3, ld_addr_lo, ld_data);
                if (a) begin
                    keep.delete();
                    foreach (mq[k]) if (mq[k].rd != alu_rd) keep.push_back(mq[k]);
                    mq = keep;
                    m_we = 1'b1; m_wa = alu_rd; m_wd = alu_data;
                end else if (mq.size() > 0) begin
                    hd = mq.pop_front();
                    m_we = 1'b1; m_wa = hd.rd; m_wd = hd.d;
                end else if (acc && ld_rd != 5'd0) begin
                    m_we = 1'b1; m_wa = ld_rd; m_wd = le.d;
                    used = 1'b1;
                end else begin
                    m_we = 1'b0;
                end
                if (acc && ld_rd != 5'd0 && !used) mq.push_back(le);
            end
        end
    end

    // Compare process: every negedge, registered and combinational outputs.
    initial begin
        logic [31:0] pm;
        bit          a;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                a  = alu_valid && (alu_rd != 5'd0);
                pm = 32'd0;
                foreach (mq[k]) if (!(a && mq[k].rd == alu_rd)) pm[mq[k].rd] = 1'b1;
                chk("model_we", {31'd0, we}, {31'd0, m_we});
                chk("model_wa", {27'd0, wa}, {27'd0, m_wa});
                chk("model_wd", wd, m_wd);
                chk("model_ld_ready", {31'd0, ld_ready}, {31'd0, (mq.size() < DEPTH)});
                chk("model_pend_mask", pend_mask, pm);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic set_in(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                          input logic lv, input logic [4:0] lr, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] ldd);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid = lv; ld_rd = lr; ld_funct3 = f3; ld_addr_lo = lo; ld_data = ldd;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        step();
        step();
        chk_en = 1'b1;
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_wa", {27'd0, wa}, 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        chk("rst_ready", {31'd0, ld_ready}, 32'd1);
        rst_n = 1'b1;

        // LB from byte 1, sign-extended
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 3'b000, 2'd1, 32'h1234_8056);
        step();
        chk("lb_we", {31'd0, we}, 32'd1);
        chk("lb_wa", {27'd0, wa}, 32'd5);
        chk("lb_wd", wd, 32'hFFFF_FF80);

        // LHU / LH from upper half
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 3'b101, 2'd2, 32'h8001_ABCD);
        step();
        chk("lhu_wa", {27'd0, wa}, 32'd9);
        chk("lhu_wd", wd, 32'h0000_8001);
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 3'b001, 2'd2, 32'h8001_ABCD);
        step();
        chk("lh_wd", wd, 32'hFFFF_8001);

        // ALU and load in the same cycle
        set_in(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 3'b010, 2'd0, 32'h55);
        step();
        chk("same_c1_wa", {27'd0, wa}, 32'd3);
        chk("same_c1_wd", wd, 32'hA);
        idle();
        #1;
        chk("same_c1_pend", pend_mask, 32'h0000_0010);
        step();
        chk("same_c2_wa", {27'd0, wa}, 32'd4);
        chk("same_c2_wd", wd, 32'h55);
        chk("same_c2_pend", pend_mask, 32'd0);
        step();

        // ALU busy for 4 cycles while loads rd1..3 are offered
        set_in(1'b1, 5'd10, 32'h100, 1'b1, 5'd1, 3'b010, 2'd0, 32'h11);
        step();
        set_in(1'b1, 5'd11, 32'h101, 1'b1, 5'd2, 3'b010, 2'd0, 32'h22);
        step();
        set_in(1'b1, 5'd12, 32'h102, 1'b1, 5'd3, 3'b010, 2'd0, 32'h33);
        #1;
        chk("busy_ready_full", {31'd0, ld_ready}, 32'd0);
        step();
        set_in(1'b1, 5'd13, 32'h103, 1'b1, 5'd3, 3'b010, 2'd0, 32'h33);
        step();
        chk("busy_alu_last_wa", {27'd0, wa}, 32'd13);
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 3'b010, 2'd0, 32'h33);
        #1;
        chk("busy_ready_still_full", {31'd0, ld_ready}, 32'd0);
        step();
        chk("busy_pop1_wa", {27'd0, wa}, 32'd1);
        chk("busy_pop1_wd", wd, 32'h11);
        #1;
        chk("busy_ready_free", {31'd0, ld_ready}, 32'd1);
        step();
        chk("busy_pop2_wa", {27'd0, wa}, 32'd2);
        idle();
        step();
        chk("busy_pop3_wa", {27'd0, wa}, 32'd3);
        chk("busy_pop3_wd", wd, 32'h33);
        step();
        chk("busy_idle_we", {31'd0, we}, 32'd0);
        chk("busy_idle_wa_hold", {27'd0, wa}, 32'd3);

        // x0 filtering
        set_in(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd6, 3'b010, 2'd0, 32'h66);
        step();
        chk("x0_alu_wa", {27'd0, wa}, 32'd6);
        chk("x0_alu_wd", wd, 32'h66);
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 3'b010, 2'd0, 32'h99);
        step();
        chk("x0_ld_we", {31'd0, we}, 32'd0);
        chk("x0_ld_wa_hold", {27'd0, wa}, 32'd6);

        // WAW kill of a queued load
        set_in(1'b1, 5'd20, 32'hAA, 1'b1, 5'd7, 3'b010, 2'd0, 32'h77);
        step();
        chk("waw_alu_wa", {27'd0, wa}, 32'd20);
        idle();
        #1;
        chk("waw_pend_set", pend_mask, 32'h0000_0080);
        set_in(1'b1, 5'd7, 32'hBEEF, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
        #1;
        chk("waw_pend_clear", pend_mask, 32'd0);
        step();
        chk("waw_wa", {27'd0, wa}, 32'd7);
        chk("waw_wd", wd, 32'hBEEF);
        idle();
        step();
        chk("waw_no_late_we", {31'd0, we}, 32'd0);
        chk("waw_wd_hold", wd, 32'hBEEF);
        step();
        chk("waw_no_late_we2", {31'd0, we}, 32'd0);

        // Full queue, async reset mid-cycle
        set_in(1'b1, 5'd21, 32'h1, 1'b1, 5'd8, 3'b010, 2'd0, 32'h88);
        step();
        set_in(1'b1, 5'd22, 32'h2, 1'b1, 5'd9, 3'b010, 2'd0, 32'h99);
        step();
        set_in(1'b1, 5'd23, 32'h3, 1'b1, 5'd10, 3'b010, 2'd0, 32'hAB);
        #1;
        chk("full_ready", {31'd0, ld_ready}, 32'd0);
        chk("full_pend", pend_mask, 32'h0000_0300);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_we", {31'd0, we}, 32'd0);
        chk("arst_wa", {27'd0, wa}, 32'd0);
        chk("arst_wd", wd, 32'd0);
        chk("arst_pend", pend_mask, 32'd0);
        chk("arst_ready", {31'd0, ld_ready}, 32'd1);
        idle();
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_we1", {31'd0, we}, 32'd0);
        step();
        chk("post_rst_we2", {31'd0, we}, 32'd0);
        chk("post_rst_pend", pend_mask, 32'd0);

        // LBU from byte 3 after reset
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 3'b100, 2'd3, 32'hF000_0000);
        step();
        chk("lbu_wa", {27'd0, wa}, 32'd11);
        chk("lbu_wd", wd, 32'h0000_00F0);
        idle();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
